// File: rtl/cpu_hazard_scoreboard_pkg.sv
// Shared CPU pipeline constants: register file geometry, stat widths, named register indices.
// Imported by decode, execute, register file and the hazard scoreboard.
package cpu_hazard_scoreboard_pkg;

  localparam int unsigned CPU_NREGS     = 16;
  localparam int unsigned CPU_REG_IDX_W = 4;
  localparam int unsigned STAT_W        = 16;

  localparam logic [CPU_REG_IDX_W-1:0] REG_R0 = 4'd0;
  localparam logic [CPU_REG_IDX_W-1:0] REG_SP = 4'd13;
  localparam logic [CPU_REG_IDX_W-1:0] REG_LR = 4'd14;
  localparam logic [CPU_REG_IDX_W-1:0] REG_PC = 4'd15;

endpackage

// File: rtl/cpu_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports: clk_i, rst_ni (async active-low), inc_i, clr_i, cnt_o (WIDTH bits, stops at MAX).
module cpu_sat_counter #(
  parameter int unsigned     WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX  = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_hazard_scoreboard.sv
// Register scoreboard: tracks destination registers with a write in flight and raises a single
// stall for RAW/WAW hazards or when the in-flight limit is reached. Keeps stall statistics,
// a sticky bad-writeback error and a sticky stall watchdog.
// Ports:
//   clk_i, rst_i (async active-low)
//   issue_valid_i/issue_we_i/issue_widx_i  decoded instruction and its destination
//   rda_en_i/rda_idx_i, rdb_en_i/rdb_idx_i operand reads
//   wb_en_i/wb_idx_i                       execute writeback
//   flush_i                                drop all in-flight tracking
//   stall_o (combinational), pending_o, inflight_o, stall_cnt_o, err_o, timeout_o
module cpu_hazard_scoreboard
  import cpu_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS        = CPU_NREGS,
  parameter int unsigned IDX_W        = CPU_REG_IDX_W,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic              issue_we_i,
  input  logic [IDX_W-1:0]  issue_widx_i,
  input  logic              rda_en_i,
  input  logic [IDX_W-1:0]  rda_idx_i,
  input  logic              rdb_en_i,
  input  logic [IDX_W-1:0]  rdb_idx_i,
  input  logic              wb_en_i,
  input  logic [IDX_W-1:0]  wb_idx_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [NREGS-1:0]  pending_o,
  output logic [CNT_W-1:0]  inflight_o,
  output logic [STAT_W-1:0] stall_cnt_o,
  output logic              err_o,
  output logic              timeout_o
);

  logic [NREGS-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;
  logic [STAT_W-1:0] run_cnt;

  logic              raw, waw, full;
  logic              set_en, wb_hit;
  logic [NREGS-1:0]  set_vec, clr_vec;

  // Hazard detection; no writeback bypass, so a register retiring this cycle still stalls
  always_comb begin
    raw     = (rda_en_i & pending_q[rda_idx_i]) | (rdb_en_i & pending_q[rdb_idx_i]);
    waw     = issue_we_i & pending_q[issue_widx_i];
    full    = issue_we_i & (inflight_q == CNT_W'(MAX_INFLIGHT));
    stall_o = issue_valid_i & (raw | waw | full);
  end

  // Pending set/clear; set and clear never share an index because WAW blocks the set
  always_comb begin
    set_en     = issue_valid_i & ~stall_o & issue_we_i;
    wb_hit     = wb_en_i & pending_q[wb_idx_i];
    set_vec    = set_en ? (NREGS'(1) << issue_widx_i) : '0;
    clr_vec    = wb_hit ? (NREGS'(1) << wb_idx_i) : '0;
    pending_d  = (pending_q | set_vec) & ~clr_vec;
    inflight_d = inflight_q + CNT_W'(set_en) - CNT_W'(wb_hit);
    err_d      = err_q | (wb_en_i & ~wb_hit);
    // Watchdog trips on the stall cycle that brings the run to TIMEOUT
    timeout_d  = timeout_q | (stall_o & (run_cnt == STAT_W'(TIMEOUT - 1)));
    if (flush_i) begin
      pending_d  = '0;
      inflight_d = '0;
      err_d      = err_q;
      timeout_d  = 1'b0;
    end
  end

  // Scoreboard state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
    end
  end

  // Total stalled cycles, saturating
  cpu_sat_counter #(
    .WIDTH (STAT_W),
    .MAX   ('1)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .inc_i  (stall_o),
    .clr_i  (1'b0),
    .cnt_o  (stall_cnt_o)
  );

  // Length of the current consecutive stall run
  cpu_sat_counter #(
    .WIDTH (STAT_W),
    .MAX   (STAT_W'(TIMEOUT))
  ) u_run_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .inc_i  (stall_o),
    .clr_i  (~stall_o | flush_i),
    .cnt_o  (run_cnt)
  );

  assign pending_o  = pending_q;
  assign inflight_o = inflight_q;
  assign err_o      = err_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// Randomized and directed bench for cpu_hazard_scoreboard with a queue-based scoreboard.
module tb_cpu_hazard_scoreboard;

  localparam int NR      = 16;
  localparam int MAXF    = 4;
  localparam int TIMEOUT = 8;

  logic        clk, rst_i;
  logic        issue_valid_i, issue_we_i, rda_en_i, rdb_en_i, wb_en_i, flush_i;
  logic [3:0]  issue_widx_i, rda_idx_i, rdb_idx_i, wb_idx_i;
  logic        stall_o, err_o, timeout_o;
  logic [15:0] pending_o;
  logic [2:0]  inflight_o;
  logic [15:0] stall_cnt_o;

  cpu_hazard_scoreboard #(
    .NREGS(16), .IDX_W(4), .MAX_INFLIGHT(MAXF), .CNT_W(3), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i), .issue_widx_i(issue_widx_i),
    .rda_en_i(rda_en_i), .rda_idx_i(rda_idx_i), .rdb_en_i(rdb_en_i), .rdb_idx_i(rdb_idx_i),
    .wb_en_i(wb_en_i), .wb_idx_i(wb_idx_i), .flush_i(flush_i),
    .stall_o(stall_o), .pending_o(pending_o), .inflight_o(inflight_o),
    .stall_cnt_o(stall_cnt_o), .err_o(err_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          stall;
    bit [15:0]   pend;
    int          infl;
    int          scnt;
    bit          err;
    bit          tmo;
  } exp_t;

  exp_t      exp_q[$];
  int        n_checks = 0;
  int        n_pass   = 0;
  bit        mon_en   = 0;

  // Reference model: set of pending registers plus plain counters
  bit [15:0] m_pend;
  int        m_scnt, m_run;
  bit        m_err, m_tmo;

  function automatic void chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endfunction

  // Drive one cycle, push the expected view of that cycle, advance the model across the edge
  task automatic step(input bit v, input bit we, input int wi, input bit ae, input int ai,
                      input bit be, input int bi, input bit wbe, input int wbi, input bit fl);
    exp_t e;
    bit   hazard, st, hit;
    issue_valid_i = v;  issue_we_i = we;  issue_widx_i = 4'(wi);
    rda_en_i = ae;  rda_idx_i = 4'(ai);  rdb_en_i = be;  rdb_idx_i = 4'(bi);
    wb_en_i = wbe;  wb_idx_i = 4'(wbi);  flush_i = fl;
    hazard = (ae && m_pend[ai]) || (be && m_pend[bi]) || (we && m_pend[wi]) ||
             (we && $countones(m_pend) == MAXF);
    st = v && hazard;
    e.stall = st;  e.pend = m_pend;  e.infl = $countones(m_pend);
    e.scnt = m_scnt;  e.err = m_err;  e.tmo = m_tmo;
    exp_q.push_back(e);
    if (st && m_scnt < 65535) m_scnt++;
    if (fl) begin
      m_pend = '0;  m_tmo = 0;  m_run = 0;
    end else begin
      hit = wbe && m_pend[wbi];
      if (wbe && !hit) m_err = 1;
      if (v && !st && we) m_pend[wi] = 1'b1;
      if (hit) m_pend[wbi] = 1'b0;
      if (!st) m_run = 0;
      else if (m_run < TIMEOUT) m_run++;
      if (m_run == TIMEOUT) m_tmo = 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL exp_queue: empty at %0t, expected a pending record", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("stall_o",     int'(stall_o),     int'(e.stall));
        chk("pending_o",   int'(pending_o),   int'(e.pend));
        chk("inflight_o",  int'(inflight_o),  e.infl);
        chk("stall_cnt_o", int'(stall_cnt_o), e.scnt);
        chk("err_o",       int'(err_o),       int'(e.err));
        chk("timeout_o",   int'(timeout_o),   int'(e.tmo));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int pick_pending();
    int c[$];
    for (int i = 0; i < NR; i++) if (m_pend[i]) c.push_back(i);
    if (c.size() == 0) return int'($urandom_range(0, NR - 1));
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  initial begin
    m_pend = '0;  m_scnt = 0;  m_run = 0;  m_err = 0;  m_tmo = 0;
    rst_i = 1'b0;
    issue_valid_i = 1;  issue_we_i = 1;  issue_widx_i = 4'd2;
    rda_en_i = 1;  rda_idx_i = 4'd2;  rdb_en_i = 0;  rdb_idx_i = 4'd0;
    wb_en_i = 0;  wb_idx_i = 4'd0;  flush_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall",   int'(stall_o),     0);
    chk("rst_pending", int'(pending_o),   0);
    chk("rst_infl",    int'(inflight_o),  0);
    chk("rst_scnt",    int'(stall_cnt_o), 0);
    chk("rst_err",     int'(err_o),       0);
    chk("rst_tmo",     int'(timeout_o),   0);
    rst_i  = 1'b1;
    mon_en = 1;

    // Watchdog: hold a RAW stall for TIMEOUT cycles, then flush
    step(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    repeat (TIMEOUT) step(1, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    chk("t5_timeout", int'(timeout_o),   1);
    chk("t5_scnt",    int'(stall_cnt_o), 8);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t5_flush_pend", int'(pending_o),   0);
    chk("t5_flush_tmo",  int'(timeout_o),   0);
    chk("t5_flush_scnt", int'(stall_cnt_o), 8);

    // RAW on r3, released the cycle after writeback
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 3, 0, 0, 1, 3, 0);
    step(1, 0, 0, 1, 3, 0, 0, 0, 0, 0);

    // In-flight limit: four writes, fifth stalls, non-writing read does not
    for (int r = 1; r <= 4; r++) step(1, 1, r, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 6, 0, 0, 0, 0, 0);
    for (int r = 1; r <= 4; r++) step(0, 0, 0, 0, 0, 0, 0, 1, r, 0);

    // WAW on r7 with same-cycle writeback
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

    // Writeback to a non-pending register
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      bit v, we, ae, be, wbe, fl;
      int wi, ai, bi, wbi;
      v   = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1) != 0;
      wi  = int'($urandom_range(0, NR - 1));
      ae  = $urandom_range(0, 1) != 0;
      ai  = ($urandom_range(0, 1) != 0) ? pick_pending() : int'($urandom_range(0, NR - 1));
      be  = $urandom_range(0, 1) != 0;
      bi  = ($urandom_range(0, 1) != 0) ? pick_pending() : int'($urandom_range(0, NR - 1));
      wbe = ($urandom_range(0, 2) != 0);
      wbi = ($urandom_range(0, 7) != 0) ? pick_pending() : int'($urandom_range(0, NR - 1));
      fl  = ($urandom_range(0, 63) == 0);
      step(v, we, wi, ae, ai, be, bi, wbe, wbi, fl);
    end

    // Async reset mid-stall with three writes pending
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int r = 1; r <= 3; r++) step(1, 1, r, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 0;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("t6_pending_before", int'(pending_o), 16'h000E);
    issue_valid_i = 1;  issue_we_i = 0;  rda_en_i = 1;  rda_idx_i = 4'd1;
    #1;
    chk("t6_stall_before", int'(stall_o), 1);
    rst_i = 1'b0;
    #1;
    chk("t6_stall",   int'(stall_o),     0);
    chk("t6_pending", int'(pending_o),   0);
    chk("t6_infl",    int'(inflight_o),  0);
    chk("t6_scnt",    int'(stall_cnt_o), 0);
    chk("t6_err",     int'(err_o),       0);
    chk("t6_tmo",     int'(timeout_o),   0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
